// File: rtl/flght_seq.sv
// ============================================================================
// Module   : flght_seq
// Brief    : Flight sequencer: IDLE -> CAL -> RUN -> LAND with watchdogs and
//            thrust slewing. Define FLGHT_SEQ_RAMP_EN to enable slew limiting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flght_seq #(
    parameter logic [25:0] CAL_TMO   = 26'd50_000_000,
    parameter logic [19:0] VLD_TMO   = 20'd1_000_000,
    parameter logic [17:0] LAND_TICK = 18'd250_000,
    parameter logic [8:0]  RAMP_STEP = 9'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic       disarm,
    input  logic       cal_done,
    input  logic       vld,
    input  logic [8:0] thrst_cmd,
    output logic       inertial_cal,
    output logic [8:0] thrst,
    output logic       motors_off,
    output logic [1:0] state,
    output logic       fault
);

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_CAL  = 2'b01;
    localparam logic [1:0] c_RUN  = 2'b10;
    localparam logic [1:0] c_LAND = 2'b11;

    logic [1:0]  r_state;
    logic [8:0]  r_thrst;
    logic        r_inertial_cal;
    logic        r_motors_off;
    logic        r_fault;
    logic [25:0] r_cal_cnt;
    logic [19:0] r_vld_cnt;
    logic        w_cal_tmo;
    logic        w_vld_tmo;

    assign w_cal_tmo = (r_cal_cnt == CAL_TMO - 26'd1);
    assign w_vld_tmo = (r_vld_cnt == VLD_TMO - 20'd1);

    // Counters are held at zero outside their own state, so each entry starts at 0.
    always_ff @(posedge clk) begin
        if (rst || r_state != c_CAL) begin
            r_cal_cnt <= '0;
        end else if (r_cal_cnt != '1) begin
            r_cal_cnt <= r_cal_cnt + 26'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != c_RUN || vld) begin
            r_vld_cnt <= '0;
        end else if (r_vld_cnt != '1) begin
            r_vld_cnt <= r_vld_cnt + 20'd1;
        end
    end

`ifdef FLGHT_SEQ_RAMP_EN
    logic [17:0] r_land_cnt;
    logic        w_land_tick;
    logic [9:0]  w_cur;
    logic [9:0]  w_cmd;
    logic [9:0]  w_step;
    logic [8:0]  w_ramp;
    logic [8:0]  w_land_dec;

    assign w_land_tick = (r_land_cnt == LAND_TICK - 18'd1);
    assign w_cur       = {1'b0, r_thrst};
    assign w_cmd       = {1'b0, thrst_cmd};
    assign w_step      = {1'b0, RAMP_STEP};
    assign w_land_dec  = (w_cur > w_step) ? 9'(w_cur - w_step) : 9'd0;

    always_ff @(posedge clk) begin
        if (rst || r_state != c_LAND || w_land_tick) begin
            r_land_cnt <= '0;
        end else if (r_land_cnt != '1) begin
            r_land_cnt <= r_land_cnt + 18'd1;
        end
    end

    // Within one step of the command we land exactly on it; otherwise move one step.
    always_comb begin
        w_ramp = thrst_cmd;
        if (w_cmd > w_cur) begin
            if (w_cmd - w_cur > w_step) begin
                w_ramp = 9'(w_cur + w_step);
            end
        end else if (w_cur - w_cmd > w_step) begin
            w_ramp = 9'(w_cur - w_step);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_thrst        <= '0;
            r_inertial_cal <= 1'b0;
            r_motors_off   <= 1'b1;
            r_fault        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (arm && !disarm) begin
                        r_state        <= c_CAL;
                        r_fault        <= 1'b0;
                        r_inertial_cal <= 1'b1;
                        r_motors_off   <= 1'b0;
                        r_thrst        <= '0;
                    end
                end
                c_CAL: begin
                    if (disarm || (w_cal_tmo && !cal_done)) begin
                        r_state        <= c_IDLE;
                        r_inertial_cal <= 1'b0;
                        r_motors_off   <= 1'b1;
                        r_thrst        <= '0;
                        if (!disarm) begin
                            r_fault <= 1'b1;
                        end
                    end else if (cal_done) begin
                        r_state        <= c_RUN;
                        r_inertial_cal <= 1'b0;
                    end
                end
                c_RUN: begin
                    if (disarm || (w_vld_tmo && !vld)) begin
                        r_state <= c_LAND;
`ifndef FLGHT_SEQ_RAMP_EN
                        r_thrst <= '0;
`endif
                        if (!disarm) begin
                            r_fault <= 1'b1;
                        end
                    end else if (vld) begin
`ifdef FLGHT_SEQ_RAMP_EN
                        r_thrst <= w_ramp;
`else
                        r_thrst <= thrst_cmd;
`endif
                    end
                end
                default: begin
                    if (r_thrst == '0) begin
                        r_state      <= c_IDLE;
                        r_motors_off <= 1'b1;
`ifdef FLGHT_SEQ_RAMP_EN
                    end else if (w_land_tick) begin
                        r_thrst <= w_land_dec;
                        if (w_land_dec == '0) begin
                            r_state      <= c_IDLE;
                            r_motors_off <= 1'b1;
                        end
`endif
                    end
                end
            endcase
        end
    end

    assign state        = r_state;
    assign thrst        = r_thrst;
    assign inertial_cal = r_inertial_cal;
    assign motors_off   = r_motors_off;
    assign fault        = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_flght_seq.sv
// ============================================================================
// Module   : tb_flght_seq
// Brief    : Scoreboard bench for flght_seq; expectations follow FLGHT_SEQ_RAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flght_seq;

`ifdef FLGHT_SEQ_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CAL  = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] LAND = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       cal_done = 1'b0;
    logic       vld = 1'b0;
    logic [8:0] thrst_cmd = 9'd0;
    logic       inertial_cal;
    logic [8:0] thrst;
    logic       motors_off;
    logic [1:0] state;
    logic       fault;

    always #5 clk = ~clk;

    flght_seq #(
        .CAL_TMO  (26'd100),
        .VLD_TMO  (20'd50),
        .LAND_TICK(18'd10),
        .RAMP_STEP(9'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .disarm      (disarm),
        .cal_done    (cal_done),
        .vld         (vld),
        .thrst_cmd   (thrst_cmd),
        .inertial_cal(inertial_cal),
        .thrst       (thrst),
        .motors_off  (motors_off),
        .state       (state),
        .fault       (fault)
    );

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [8:0] th;
        logic       cal;
        logic       moff;
        logic       flt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Monitor: outputs settle after each posedge, so compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if ({state, thrst, inertial_cal, motors_off, fault} !==
                {e.st, e.th, e.cal, e.moff, e.flt}) begin
                n_fail++;
                $display("FAIL %s: got state=%0d thrst=%0d cal=%0b moff=%0b fault=%0b, want state=%0d thrst=%0d cal=%0b moff=%0b fault=%0b",
                         e.name, state, thrst, inertial_cal, motors_off, fault,
                         e.st, e.th, e.cal, e.moff, e.flt);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] st, input logic [8:0] th,
                              input logic cal, input logic moff, input logic flt);
        exp_t e;
        e = '{nm, st, th, cal, moff, flt};
        sb.push_back(e);
    endtask

    task automatic check_now(input string nm, input logic [1:0] st, input logic [8:0] th,
                             input logic cal, input logic moff, input logic flt);
        n_chk++;
        if ({state, thrst, inertial_cal, motors_off, fault} !== {st, th, cal, moff, flt}) begin
            n_fail++;
            $display("FAIL %s (immediate): got state=%0d thrst=%0d cal=%0b moff=%0b fault=%0b, want state=%0d thrst=%0d cal=%0b moff=%0b fault=%0b",
                     nm, state, thrst, inertial_cal, motors_off, fault,
                     st, th, cal, moff, flt);
        end
    endtask

    initial begin
        logic [8:0] e_th;

        tick(2);
        rst = 1'b0;
        check_now("reset_state", IDLE, 9'd0, 1'b0, 1'b1, 1'b0);
        expect_out("reset", IDLE, 9'd0, 1'b0, 1'b1, 1'b0);

        arm = 1'b1; disarm = 1'b1; tick(1); arm = 1'b0; disarm = 1'b0;
        expect_out("idle_arm_disarm_noop", IDLE, 9'd0, 1'b0, 1'b1, 1'b0);

        // Nominal flight: arm at cycle 0, cal_done sampled at cycle 20.
        arm = 1'b1; tick(1); arm = 1'b0;
        expect_out("arm_to_cal", CAL, 9'd0, 1'b1, 1'b0, 1'b0);
        tick(5); arm = 1'b1; tick(1); arm = 1'b0;
        expect_out("arm_ignored_in_cal", CAL, 9'd0, 1'b1, 1'b0, 1'b0);
        tick(13);
        expect_out("cal_cycle19", CAL, 9'd0, 1'b1, 1'b0, 1'b0);
        cal_done = 1'b1; tick(1); cal_done = 1'b0;
        expect_out("cal_done_to_run", RUN, 9'd0, 1'b0, 1'b0, 1'b0);

        thrst_cmd = 9'd100;
        for (int k = 1; k <= 26; k++) begin
            vld = 1'b1; tick(1); vld = 1'b0;
            e_th = RAMP ? ((4 * k > 100) ? 9'd100 : 9'(4 * k)) : 9'd100;
            expect_out("ramp_up_100", RUN, e_th, 1'b0, 1'b0, 1'b0);
            tick(4);
        end

        thrst_cmd = 9'd40;
        for (int k = 1; k <= 15; k++) begin
            vld = 1'b1; tick(1); vld = 1'b0;
            e_th = RAMP ? 9'(100 - 4 * k) : 9'd40;
            expect_out("ramp_down_40", RUN, e_th, 1'b0, 1'b0, 1'b0);
            tick(4);
        end

        // vld loss: last vld four cycles ago, watchdog fires 50 cycles after it.
        tick(45);
        expect_out("watchdog_edge49", RUN, 9'd40, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_now("watchdog_expired", LAND, RAMP ? 9'd40 : 9'd0, 1'b0, 1'b0, 1'b1);
        expect_out("watchdog_to_land", LAND, RAMP ? 9'd40 : 9'd0, 1'b0, 1'b0, 1'b1);
`ifdef FLGHT_SEQ_RAMP_EN
        tick(9);
        expect_out("land_before_tick", LAND, 9'd40, 1'b0, 1'b0, 1'b1);
        vld = 1'b1; thrst_cmd = 9'd300; tick(1); vld = 1'b0;
        expect_out("land_tick1_ignores_vld", LAND, 9'd36, 1'b0, 1'b0, 1'b1);
        for (int j = 2; j <= 10; j++) begin
            tick(10);
            if (j < 10) expect_out("land_descent", LAND, 9'(40 - 4 * j), 1'b0, 1'b0, 1'b1);
            else        expect_out("land_done_idle", IDLE, 9'd0, 1'b0, 1'b1, 1'b1);
        end
`else
        tick(1);
        expect_out("land_done_idle", IDLE, 9'd0, 1'b0, 1'b1, 1'b1);
`endif

        // Calibration timeout.
        arm = 1'b1; tick(1); arm = 1'b0;
        expect_out("arm_clears_fault", CAL, 9'd0, 1'b1, 1'b0, 1'b0);
        tick(99);
        expect_out("cal_cycle99", CAL, 9'd0, 1'b1, 1'b0, 1'b0);
        tick(1);
        expect_out("cal_timeout", IDLE, 9'd0, 1'b0, 1'b1, 1'b1);

        // cal_done coincident with timeout wins.
        arm = 1'b1; tick(1); arm = 1'b0;
        expect_out("rearm_clears_fault", CAL, 9'd0, 1'b1, 1'b0, 1'b0);
        tick(99);
        cal_done = 1'b1; tick(1); cal_done = 1'b0;
        expect_out("cal_done_at_timeout", RUN, 9'd0, 1'b0, 1'b0, 1'b0);

        thrst_cmd = 9'd2; vld = 1'b1; tick(1);
        expect_out("no_overshoot_2", RUN, 9'd2, 1'b0, 1'b0, 1'b0);
        thrst_cmd = 9'd511;
        tick(127);
        expect_out("ramp_to_510", RUN, RAMP ? 9'd510 : 9'd511, 1'b0, 1'b0, 1'b0);
        tick(3);
        expect_out("saturate_511", RUN, 9'd511, 1'b0, 1'b0, 1'b0);
        vld = 1'b0;

        // vld coincident with watchdog expiry keeps RUN.
        tick(49);
        vld = 1'b1; tick(1); vld = 1'b0;
        expect_out("vld_at_watchdog", RUN, 9'd511, 1'b0, 1'b0, 1'b0);

        arm = 1'b1; disarm = 1'b1; tick(1); arm = 1'b0; disarm = 1'b0;
        expect_out("run_arm_disarm_land", LAND, RAMP ? 9'd511 : 9'd0, 1'b0, 1'b0, 1'b0);
`ifdef FLGHT_SEQ_RAMP_EN
        tick(1270);
        expect_out("land_floor_3", LAND, 9'd3, 1'b0, 1'b0, 1'b0);
        tick(10);
`else
        tick(1);
`endif
        expect_out("land_floor_idle", IDLE, 9'd0, 1'b0, 1'b1, 1'b0);

        arm = 1'b1; tick(1); arm = 1'b0;
        tick(3);
        disarm = 1'b1; tick(1); disarm = 1'b0;
        expect_out("disarm_in_cal", IDLE, 9'd0, 1'b0, 1'b1, 1'b0);

        arm = 1'b1; tick(1); arm = 1'b0;
        cal_done = 1'b1; tick(1); cal_done = 1'b0;
        disarm = 1'b1; tick(1); disarm = 1'b0;
        expect_out("land_entry_zero", LAND, 9'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        expect_out("land_zero_to_idle", IDLE, 9'd0, 1'b0, 1'b1, 1'b0);

        // Reset mid-LAND with thrust 20 and fault set.
        arm = 1'b1; tick(1); arm = 1'b0;
        cal_done = 1'b1; tick(1); cal_done = 1'b0;
        thrst_cmd = 9'd20; vld = 1'b1; tick(5); vld = 1'b0;
        expect_out("run_at_20", RUN, 9'd20, 1'b0, 1'b0, 1'b0);
        tick(50);
        tick(2);
        expect_out("pre_rst", RAMP ? LAND : IDLE, RAMP ? 9'd20 : 9'd0, 1'b0, !RAMP, 1'b1);
        rst = 1'b1; arm = 1'b1; tick(1); rst = 1'b0; arm = 1'b0;
        expect_out("rst_mid_land", IDLE, 9'd0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/flght_seq.md
FLGHT_SEQ -- requirements
Module: flght_seq

Interface
REQ-001 Parameters SHALL be:
- CAL_TMO, default 26'd50_000_000: clk cycles allowed in CAL before fault.
- VLD_TMO, default 20'd1_000_000: clk cycles without vld before failsafe.
- LAND_TICK, default 18'd250_000: clk cycles per thrust decrement in LAND.
- RAMP_STEP, default 9'd4: maximum thrust change per update.

REQ-002 Ports SHALL be:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- arm  in  1  single-cycle arm request.
- disarm  in  1  single-cycle disarm request.
- cal_done  in  1  inertial calibration complete.
- vld  in  1  new inertial reading strobe.
- thrst_cmd  in  9  requested thrust, unsigned.
- inertial_cal  out  1  drives flight-control calibration mux.
- thrst  out  9  slewed thrust to flight control, unsigned.
- motors_off  out  1  forces ESC outputs to zero.
- state  out  2  current state encoding.
- fault  out  1  sticky fault flag.

Function
REQ-003 States SHALL be IDLE=2'b00, CAL=2'b01, RUN=2'b10, LAND=2'b11; all outputs registered; a transition triggered by inputs sampled at edge N SHALL be visible on the outputs after edge N.
REQ-004 In IDLE the block SHALL hold thrst=0, inertial_cal=0 and motors_off=1; arm SHALL move it to CAL, clear fault, and clear the CAL counter.
REQ-005 In CAL the block SHALL hold inertial_cal=1, motors_off=0 and thrst=0, with these exits:
- cal_done -> RUN.
- CAL counter reaching CAL_TMO-1 without cal_done -> IDLE with fault=1.
- disarm -> IDLE.
REQ-006 In RUN the block SHALL hold inertial_cal=0 and motors_off=0.
- On each vld, thrst SHALL step toward thrst_cmd by RAMP_STEP.
- If |thrst_cmd-thrst| <= RAMP_STEP, thrst SHALL equal thrst_cmd (no overshoot).
- Ramp arithmetic SHALL be 10-bit, with no wrap below 0 or above 511.
REQ-007 In RUN a watchdog counter SHALL clear on vld and otherwise increment; reaching VLD_TMO-1 SHALL move to LAND and set fault=1.
REQ-008 disarm in RUN SHALL move to LAND with fault unchanged.
REQ-009 In LAND the block SHALL hold motors_off=0 and inertial_cal=0, and SHALL ignore vld and thrst_cmd.
- thrst SHALL decrement by RAMP_STEP (floored at 0) once every LAND_TICK cycles.
- When thrst==0 at a tick boundary, or on entry with thrst==0, the block SHALL go to IDLE.
REQ-010 arm SHALL be ignored in CAL, RUN and LAND.
REQ-011 Simultaneous arm and disarm SHALL be treated as disarm only; in IDLE the pair SHALL be a no-op.
REQ-012 Simultaneous vld and watchdog expiry SHALL count as vld: stay in RUN.
REQ-013 Simultaneous cal_done and CAL timeout SHALL count as cal_done: go to RUN, no fault.
REQ-014 fault SHALL be sticky and SHALL clear only on an accepted arm or on rst.
REQ-015 All counters SHALL saturate and never wrap, and SHALL clear on every state entry.

Reset
REQ-016 rst high at a clk edge SHALL force state=IDLE, thrst=0, inertial_cal=0, motors_off=1, fault=0, and all counters to 0, regardless of current state (including mid-CAL and mid-LAND).
REQ-017 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-018 With FLGHT_SEQ_RAMP_EN defined, REQ-006 and REQ-009 slew limiting SHALL apply as written.
REQ-019 Without FLGHT_SEQ_RAMP_EN:
- In RUN, thrst SHALL register thrst_cmd on every vld.
- LAND SHALL set thrst=0 on entry and go to IDLE on the next cycle.
- RAMP_STEP and LAND_TICK SHALL be unused.

Verification (FLGHT_SEQ_RAMP_EN defined unless noted; bench overrides CAL_TMO=100, VLD_TMO=50, LAND_TICK=10, RAMP_STEP=4)
REQ-020 Nominal flight: arm, then cal_done at cycle 20 -> inertial_cal=1 for cycles 1-20 and state=RUN; then thrst_cmd=9'd100 with vld every 5 cycles -> thrst 4,8,...,100 after 25 vlds, then holds at 100.
REQ-021 Cal timeout: arm and never assert cal_done -> state returns to IDLE at cycle 100 with fault=1 and motors_off=1; next arm clears fault.
REQ-022 vld loss: in RUN at thrst=40, stop vld -> LAND after 50 cycles with fault=1; thrst drops by 4 every 10 cycles, reaches 0 at cycle 100, then IDLE.
REQ-023 Edge cases:
- arm and disarm in the same cycle while in RUN -> LAND.
- thrst_cmd=9'd2 from thrst=0 -> 2 in one vld (no overshoot).
- thrst_cmd=9'd511 -> saturates at 511 with no wrap.
REQ-024 rst asserted mid-LAND (thrst=20) -> next cycle state=IDLE, thrst=0, fault=0.
REQ-025 FLGHT_SEQ_RAMP_EN undefined:
- vld with thrst_cmd=200 in RUN -> thrst=200 next cycle.
- disarm -> thrst=0 next cycle, then IDLE one cycle later.
